// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the pipeline request/response and word-memory signals of
// mem_access_unit.
//   Request  : req, we, size, sign_ext, addr, wdata          (pipeline -> unit)
//   Response : busy, done, rdata, misalign                     (unit -> pipeline)
//   Memory   : mem_a, mem_wd, mem_we (unit -> memory), mem_rd (memory -> unit)
// Modport slave is the unit's view; master is the pipeline/memory side.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sign_ext;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic [31:0]       rdata;
   logic              misalign;
   logic [ADDR_W-1:0] mem_a;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rd;

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_rd,
      output busy, done, rdata, misalign, mem_a, mem_wd, mem_we
   );

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_rd,
      input  busy, done, rdata, misalign, mem_a, mem_wd, mem_we
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store initiator between the pipeline M stage and a
// word-organised data memory. Byte/halfword/word requests become word-only accesses;
// partial stores use read-modify-write, loads are lane-extracted and sign/zero-extended.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - mem_access_unit_if.slave (request, response and memory signals)
module mem_access_unit #(
   parameter int unsigned ADDR_W = 12
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e            state_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              sext_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       old_q;
   logic [31:0]       rdata_q;
   logic              done_q;
   logic              misalign_q;

   logic              req_bad;
   logic [31:0]       load_val;
   logic [31:0]       merged;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic              unused_addr_hi;

   // Address bits above the memory range are intentionally dropped.
   assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

   // Rejected requests: illegal size or a lane not aligned to its own width.
   assign req_bad = (bus.size == 2'b11) ||
                    (bus.size == 2'b01 && bus.addr[0]) ||
                    (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

   // Lane extraction and extension of the word currently read from memory.
   always_comb begin
      byte_v   = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
      half_v   = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
      load_val = bus.mem_rd;
      case (size_q)
         2'b00:   load_val = {{24{sext_q & byte_v[7]}}, byte_v};
         2'b01:   load_val = {{16{sext_q & half_v[15]}}, half_v};
         default: load_val = bus.mem_rd;
      endcase
   end

   // Store word: old word with the addressed lane replaced (whole word for size 10).
   always_comb begin
      merged = old_q;
      case (size_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.req) begin
                  we_q    <= bus.we;
                  size_q  <= bus.size;
                  sext_q  <= bus.sign_ext;
                  addr_q  <= bus.addr[ADDR_W+1:0];
                  wdata_q <= bus.wdata;
                  if (req_bad) begin
                     state_q    <= StDone;
                     done_q     <= 1'b1;
                     misalign_q <= 1'b1;
                  end else if (bus.we && bus.size == 2'b10) begin
                     state_q <= StWr;
                  end else begin
                     state_q <= StRd;
                  end
               end
            end
            StRd: begin
               if (we_q) begin
                  old_q   <= bus.mem_rd;
                  state_q <= StWr;
               end else begin
                  rdata_q <= load_val;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StWr: begin
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               done_q     <= 1'b0;
               misalign_q <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Decoded from state and latched fields only, so reset drops mem_we at once.
   assign bus.busy     = (state_q != StIdle);
   assign bus.mem_a    = (state_q == StRd || state_q == StWr) ? addr_q[ADDR_W+1:2] : '0;
   assign bus.mem_we   = (state_q == StWr);
   assign bus.mem_wd   = (state_q == StWr) ? merged : 32'h0;
   assign bus.done     = done_q;
   assign bus.misalign = misalign_q;
   assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int unsigned AW = 12;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        pre;
      logic [31:0] pre_val;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      int          exp_lat;
      int          exp_we;
      logic [31:0] exp_word;
   } vec_t;

   logic clk;
   logic reset;

   mem_access_unit_if #(.ADDR_W(AW)) bus ();

   mem_access_unit #(.ADDR_W(AW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [4096];
   logic        pre_en;
   logic [11:0] pre_idx;
   logic [31:0] pre_val;
   int          we_cnt;
   logic [31:0] last_wd;
   int          n_chk;
   int          n_fail;
   logic [31:0] ref_mem [16];
   logic [31:0] ref_rdata;
   vec_t        tbl [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rd = mem[bus.mem_a];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
      else if (pre_en) mem[pre_idx] <= pre_val;
   end

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         we_cnt  = we_cnt + 1;
         last_wd = bus.mem_wd;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
      if (idx < 16) ref_mem[idx[3:0]] = val;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (bus.busy && k < 10) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      if (v.pre) preload(v.addr[13:2], v.pre_val);
      wait_idle();
      we_cnt       = 0;
      bus.req      = 1'b1;
      bus.we       = v.we;
      bus.size     = v.size;
      bus.sign_ext = v.sext;
      bus.addr     = v.addr;
      bus.wdata    = v.wdata;
      lat = 0;
      do begin
         @(posedge clk);
         #1 bus.req = 1'b0;
         lat++;
      end while (bus.done !== 1'b1 && lat < 8);
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " misalign"}, {31'b0, bus.misalign}, {31'b0, v.exp_mis});
      chk({tag, " rdata"}, bus.rdata, v.exp_rdata);
      @(negedge clk);
      chk({tag, " mem_we cycles"}, we_cnt, v.exp_we);
      if (v.exp_we != 0) chk({tag, " mem_wd"}, last_wd, v.exp_word);
      chk({tag, " memory word"}, mem[v.addr[13:2]], v.exp_word);
      @(posedge clk);
      #1 chk({tag, " done pulse width"}, {31'b0, bus.done}, 32'h0);
      ref_rdata = v.exp_rdata;
   endtask

   // Reference model: plain lane/mask arithmetic over a 16-word shadow memory.
   task automatic model(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata, output vec_t v);
      logic [31:0] w;
      logic [31:0] mask;
      logic [31:0] val;
      int          sh;
      logic        bad;
      bad = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0);
      w   = ref_mem[addr[5:2]];
      v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
      v.pre = 1'b0; v.pre_val = 32'h0;
      v.exp_mis = bad;
      v.exp_we  = 0;
      if (bad) begin
         v.exp_lat = 1;
      end else if (!we) begin
         v.exp_lat = 2;
         if (size == 0) begin
            sh  = 8 * int'(addr[1:0]);
            val = (w >> sh) & 32'hFF;
            if (sext && val >= 32'h80) val = val | 32'hFFFF_FF00;
         end else if (size == 1) begin
            sh  = 16 * int'(addr[1]);
            val = (w >> sh) & 32'hFFFF;
            if (sext && val >= 32'h8000) val = val | 32'hFFFF_0000;
         end else begin
            val = w;
         end
         ref_rdata = val;
      end else begin
         v.exp_we  = 1;
         v.exp_lat = (size == 2) ? 2 : 3;
         if (size == 0) begin
            sh = 8 * int'(addr[1:0]);
            mask = 32'hFF << sh;
         end else if (size == 1) begin
            sh = 16 * int'(addr[1]);
            mask = 32'hFFFF << sh;
         end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
         end
         ref_mem[addr[5:2]] = (w & ~mask) | ((wdata << sh) & mask);
      end
      v.exp_rdata = ref_rdata;
      v.exp_word  = ref_mem[addr[5:2]];
   endtask

   initial begin
      vec_t rv;
      n_chk = 0; n_fail = 0;
      we_cnt = 0; last_wd = 32'h0;
      pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      ref_rdata = 32'h0;

      //          we  sz    sx  addr   wdata         pre pre_val       rdata        mis lat we word
      tbl[0]  = '{0, 2'd0, 1, 32'h0E, 32'h0,        1, 32'h80FF7F01, 32'hFFFFFFFF, 0, 2, 0, 32'h80FF7F01};
      tbl[1]  = '{0, 2'd0, 1, 32'h0F, 32'h0,        0, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h80FF7F01};
      tbl[2]  = '{0, 2'd0, 0, 32'h0F, 32'h0,        0, 32'h0,        32'h00000080, 0, 2, 0, 32'h80FF7F01};
      tbl[3]  = '{0, 2'd1, 1, 32'h0E, 32'h0,        0, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h80FF7F01};
      tbl[4]  = '{0, 2'd1, 0, 32'h0E, 32'h0,        0, 32'h0,        32'h000080FF, 0, 2, 0, 32'h80FF7F01};
      tbl[5]  = '{0, 2'd2, 0, 32'h0C, 32'h0,        0, 32'h0,        32'h80FF7F01, 0, 2, 0, 32'h80FF7F01};
      tbl[6]  = '{1, 2'd0, 0, 32'h0D, 32'h000000AB, 0, 32'h0,        32'h80FF7F01, 0, 3, 1, 32'h80FFAB01};
      tbl[7]  = '{1, 2'd1, 0, 32'h0E, 32'h00001234, 1, 32'h80FF7F01, 32'h80FF7F01, 0, 3, 1, 32'h12347F01};
      tbl[8]  = '{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        32'h80FF7F01, 0, 2, 1, 32'hDEADBEEF};
      tbl[9]  = '{0, 2'd2, 0, 32'h0E, 32'h0,        0, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h12347F01};
      tbl[10] = '{0, 2'd1, 1, 32'h0D, 32'h0,        0, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h12347F01};
      tbl[11] = '{0, 2'd3, 0, 32'h0C, 32'h0,        0, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h12347F01};
      tbl[12] = '{1, 2'd3, 0, 32'h0F, 32'hFFFFFFFF, 0, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'h12347F01};
      tbl[13] = '{1, 2'd2, 0, 32'h11, 32'h0,        0, 32'h0,        32'h80FF7F01, 1, 1, 0, 32'hDEADBEEF};
      tbl[14] = '{0, 2'd0, 0, 32'h0D, 32'h0,        0, 32'h0,        32'h0000007F, 0, 2, 0, 32'h12347F01};
      tbl[15] = '{0, 2'd1, 1, 32'h12, 32'h0,        0, 32'h0,        32'hFFFFDEAD, 0, 2, 0, 32'hDEADBEEF};

      // Reset held for 3 cycles, then released.
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset busy", {31'b0, bus.busy}, 32'h0);
      chk("reset done", {31'b0, bus.done}, 32'h0);
      chk("reset misalign", {31'b0, bus.misalign}, 32'h0);
      chk("reset mem_we", {31'b0, bus.mem_we}, 32'h0);
      chk("reset rdata", bus.rdata, 32'h0);
      chk("reset mem_a", {20'h0, bus.mem_a}, 32'h0);
      chk("reset mem_wd", bus.mem_wd, 32'h0);

      // Reset asserted in the WR cycle of a byte store must suppress the write.
      preload(12'd3, 32'h80FF7F01);
      wait_idle();
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.addr = 32'h0D;
      bus.wdata = 32'h000000AB;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(posedge clk);
      #1 chk("midwr mem_we before reset", {31'b0, bus.mem_we}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("midwr mem_we after reset", {31'b0, bus.mem_we}, 32'h0);
      chk("midwr busy after reset", {31'b0, bus.busy}, 32'h0);
      @(posedge clk);
      #1 chk("midwr memory unchanged", mem[3], 32'h80FF7F01);
      @(negedge clk) reset = 1'b1;
      ref_rdata = 32'h0;

      for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // req pulsed while busy must be ignored and not queued.
      wait_idle();
      bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0C;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h10; bus.wdata = 32'h0;
      @(posedge clk);
      #1 chk("ignore done", {31'b0, bus.done}, 32'h1);
      @(negedge clk) bus.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("ignore busy", {31'b0, bus.busy}, 32'h0);
      chk("ignore memory", mem[4], 32'hDEADBEEF);
      chk("ignore rdata", bus.rdata, 32'h12347F01);
      ref_rdata = 32'h12347F01;

      // Randomized operations against the shadow-memory model.
      for (int i = 0; i < 16; i++) preload(12'(i), $urandom);
      for (int i = 0; i < 150; i++) begin
         logic       r_we;
         logic [1:0] r_sz;
         r_we = 1'($urandom % 2);
         r_sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
         model(r_we, r_sz, 1'($urandom % 2), $urandom % 64, $urandom, rv);
         run_vec(rv, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store initiator for the M stage, sitting between the pipeline and the word-organised data memory. It turns byte, halfword and word requests into word-only memory transactions. Partial stores are done as read-modify-write, and loaded bytes/halfwords are extracted and extended. The pipeline stalls on `busy` and picks up results on the `done` pulse.

## Interface
- `ADDR_W`, default 12: word-address width driven to data memory (4096 words).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: request strobe; sampled only in IDLE.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sign_ext` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` input 32: byte address.
- `wdata` input 32: store data; byte in [7:0], halfword in [15:0].
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result.
- `misalign` output 1: high together with `done` when the request was rejected.
- `mem_a` output ADDR_W: word address, equal to `addr[ADDR_W+1:2]` latched.
- `mem_wd` output 32: write word.
- `mem_we` output 1: memory write enable; memory writes on the clk edge.
- `mem_rd` input 32: memory read data, combinational from `mem_a`.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **Accept:** in IDLE, with `req`=1 at a rising edge, latch `we`, `size`, `sign_ext`, `addr` and `wdata`. `req` in any other state is ignored and is not queued.
- **Misaligned or illegal** (halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `size`=11): IDLE→DONE with `misalign`=1. No memory access; `rdata` unchanged.
- **Load:** IDLE→RD→DONE. At the edge leaving RD, register the extracted and extended value into `rdata`.
- **Store word:** IDLE→WR→DONE.
- **Store byte/half:** IDLE→RD→WR→DONE. At the edge leaving RD, register `mem_rd` as the old word. In WR, `mem_wd` is the old word with the addressed lane replaced.
- **Lanes (little-endian):**
  - Byte k occupies bits [8k+7:8k], with k=`addr[1:0]`.
  - Halfword occupies [15:0] if `addr[1]`=0, else [31:16].
- **Extension:** sign-extend from bit 7 (byte) or bit 15 (half) when `sign_ext`=1, otherwise zero-fill. Word loads pass through unchanged.
- **DONE:** always returns to IDLE on the next edge. `done`=1 for exactly that cycle.
- **`rdata` update:** changes only on load completion and holds its value across stores.
- **Memory outputs:**
  - `mem_a` is the latched word address in RD and WR, and 0 otherwise.
  - `mem_we`=1 only in WR.
  - `mem_wd` is 0 outside WR.

## Timing
- **Reset values** (asynchronous, `reset`=0): state IDLE; `busy`, `done`, `misalign`, `mem_we` = 0; `rdata`, `mem_a`, `mem_wd` = 0.
- **Reset mid-operation:** a reset asserted while in WR drops `mem_we` immediately, so no write occurs. Any in-flight request is discarded.
- **Latency:** counted as edges from the accepting edge to the edge at which `done` is high.
  - Misaligned: 1.
  - Load: 2.
  - Store word: 2.
  - Store byte/half: 3.
- **Back-to-back requests:** `req` held high through DONE is accepted at the edge leaving DONE→IDLE+1. Minimum request spacing is the latency + 1 edge.
- **Memory timing:** `mem_rd` is combinational, so RD needs exactly one cycle. The write commits at the edge ending WR.
- **Outputs:** all outputs except `busy`, `mem_a`, `mem_wd` and `mem_we` are registered. Those four are decoded from state and latched fields only, never from live inputs.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release → all outputs 0, `busy`=0. Then assert `reset`=0 mid-WR of an `sb` → `mem_we` falls within the same cycle and the memory word is unchanged.
- **Signed byte load:** memory word 3 = 0x80FF7F01; load byte, `addr`=0x0E, `sign_ext`=1 → `rdata`=0xFFFFFFFF two edges later. With `addr`=0x0F → 0xFFFFFF80. With `sign_ext`=0 → 0x00000080.
- **Halfword and word loads:** load half, `addr`=0x0E, `sign_ext`=1 → 0xFFFF80FF. Load word, `addr`=0x0C → 0x80FF7F01, with `done` a single-cycle pulse.
- **Byte store:** `sb` `wdata`=0x000000AB, `addr`=0x0D over 0x80FF7F01 → `mem_wd`=0x80FFAB01 with `mem_we` for exactly one cycle. `done` follows 3 edges after accept. `rdata` is unchanged.
- **Half and word stores:** `sh` 0x1234 at `addr`=0x0E → word 0x12347F01. `sw` 0xDEADBEEF at `addr`=0x10 → 2-edge latency with no RD state.
- **Misaligned and illegal:** load word at `addr`=0x02 and half at `addr`=0x05 → `done`=`misalign`=1 one edge later, `mem_we` never asserted, `rdata` held. `size`=11 → same behaviour. `req` pulsed while `busy`=1 → ignored.
